// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light monitor.
//  - phase_e    : phase encoding reported on the phase output
//  - err_code_e : first-violation codes reported on err_code
//  - state_e    : monitor FSM states
//  - Lamp*      : one-hot lamp vectors, ordered {Red, Yellow, Green}
//  - legal_next : the only legal successor of each tracking state
//  - phase_of   : maps an FSM state to the reported phase
package traffic_pkg;

    typedef enum logic [1:0] {
        PhUnsync = 2'd0,
        PhRed    = 2'd1,
        PhGreen  = 2'd2,
        PhYellow = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        ErrNone         = 3'd0,
        ErrNotOnehot    = 3'd1,
        ErrIllegalTrans = 3'd2,
        ErrDwellShort   = 3'd3,
        ErrDwellLong    = 3'd4
    } err_code_e;

    typedef enum logic [2:0] {
        StUnsync,
        StRed,
        StGreen,
        StYellow,
        StError
    } state_e;

    localparam logic [2:0] LampRed    = 3'b100;
    localparam logic [2:0] LampYellow = 3'b010;
    localparam logic [2:0] LampGreen  = 3'b001;

    function automatic state_e legal_next(state_e s);
        case (s)
            StRed:    return StGreen;
            StGreen:  return StYellow;
            StYellow: return StRed;
            default:  return StError;
        endcase
    endfunction

    function automatic phase_e phase_of(state_e s);
        case (s)
            StRed:    return PhRed;
            StGreen:  return PhGreen;
            StYellow: return PhYellow;
            default:  return PhUnsync; // UNSYNC and ERROR both report 0
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp/status bundle between a traffic light controller (master) and the monitor (slave).
//  Red, Yellow, Green : lamp outputs of the controller
//  clr_err            : synchronous clear request to the monitor
//  phase              : tracked phase (0 UNSYNC, 1 RED, 2 GREEN, 3 YELLOW)
//  locked             : a legal RED->GREEN has been seen
//  err, err_code      : sticky violation flag and first-violation code
//  dwell              : consecutive samples in the current phase
//  cycle_count        : completed R->G->Y->R cycles, wraps at 2^16
interface traffic_light_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             Red;
    logic             Yellow;
    logic             Green;
    logic             clr_err;
    logic [1:0]       phase;
    logic             locked;
    logic             err;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] dwell;
    logic [15:0]      cycle_count;

    modport master (
        output Red, Yellow, Green, clr_err,
        input  phase, locked, err, err_code, dwell, cycle_count
    );

    modport slave (
        input  Red, Yellow, Green, clr_err,
        output phase, locked, err, err_code, dwell, cycle_count
    );
endinterface

// File: rtl/dwell_counter.sv
// Saturating dwell counter.
//  clk_i, rst_ni : clock and asynchronous active-low reset
//  clr_i         : force count to 0 (highest priority)
//  restart_i     : load 1 (first sample of a new phase)
//  inc_i         : add 1, sticking at all-ones
//  count_o       : current count
module dwell_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             restart_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (restart_i) begin
            count_d = CNT_W'(1);
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the Red/Yellow/Green lamp outputs of a traffic light controller.
// Tracks the lamp phase, checks sequence and per-phase dwell limits, latches the first
// violation until clr_err, and counts completed R->G->Y->R cycles.
//  clk     : rising-edge clock
//  reset   : asynchronous active-low reset
//  bus_io  : slave side of traffic_light_monitor_if (lamps and clr_err in, status out)
// Parameters must satisfy 1 <= *_MIN <= *_MAX < 2^CNT_W.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned RED_MIN   = 5,
    parameter int unsigned RED_MAX   = 20,
    parameter int unsigned GREEN_MIN = 5,
    parameter int unsigned GREEN_MAX = 20,
    parameter int unsigned YEL_MIN   = 2,
    parameter int unsigned YEL_MAX   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    traffic_light_monitor_if.slave bus_io
);

    localparam logic [CNT_W-1:0] RedMin   = CNT_W'(RED_MIN);
    localparam logic [CNT_W-1:0] RedMax   = CNT_W'(RED_MAX);
    localparam logic [CNT_W-1:0] GreenMin = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] GreenMax = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] YelMin   = CNT_W'(YEL_MIN);
    localparam logic [CNT_W-1:0] YelMax   = CNT_W'(YEL_MAX);

    state_e      state_d, state_q;
    logic        err_d, err_q;
    err_code_e   code_d, code_q;
    logic        locked_d, locked_q;
    logic        partial_d, partial_q;  // current Red dwell began at resync: RED_MIN waived
    logic [15:0] cycle_d, cycle_q;

    logic [2:0]       lamps;
    logic             onehot;
    state_e           lamp_state;
    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] cur_min, cur_max;
    logic             cnt_clr, cnt_restart, cnt_inc;
    logic             viol;
    err_code_e        viol_code;

    assign lamps  = {bus_io.Red, bus_io.Yellow, bus_io.Green};
    assign onehot = (lamps == LampRed) || (lamps == LampYellow) || (lamps == LampGreen);

    always_comb begin
        case (lamps)
            LampRed:    lamp_state = StRed;
            LampGreen:  lamp_state = StGreen;
            LampYellow: lamp_state = StYellow;
            default:    lamp_state = StUnsync;
        endcase
    end

    always_comb begin
        cur_min = '0;
        cur_max = '0;
        unique case (state_q)
            StRed:    begin cur_min = RedMin;   cur_max = RedMax;   end
            StGreen:  begin cur_min = GreenMin; cur_max = GreenMax; end
            StYellow: begin cur_min = YelMin;   cur_max = YelMax;   end
            default:  ;
        endcase
    end

    dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (cnt_clr),
        .restart_i (cnt_restart),
        .inc_i     (cnt_inc),
        .count_o   (dwell)
    );

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        code_d      = code_q;
        locked_d    = locked_q;
        partial_d   = partial_q;
        cycle_d     = cycle_q;
        cnt_clr     = 1'b0;
        cnt_restart = 1'b0;
        cnt_inc     = 1'b0;
        viol        = 1'b0;
        viol_code   = ErrNone;

        unique case (state_q)
            StUnsync: begin
                if (lamps == LampRed) begin
                    state_d     = StRed;
                    cnt_restart = 1'b1;
                    partial_d   = 1'b1;
                end
            end
            StRed, StGreen, StYellow: begin
                if (!onehot) begin
                    viol      = 1'b1;
                    viol_code = ErrNotOnehot;
                end else if (lamp_state == state_q) begin
                    // dwell never exceeds MAX here, so >= MAX means the new dwell would
                    if (dwell >= cur_max) begin
                        viol      = 1'b1;
                        viol_code = ErrDwellLong;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else if (lamp_state != legal_next(state_q)) begin
                    viol      = 1'b1;
                    viol_code = ErrIllegalTrans;
                end else if ((dwell < cur_min) && !((state_q == StRed) && partial_q)) begin
                    viol      = 1'b1;
                    viol_code = ErrDwellShort;
                end else begin
                    state_d     = lamp_state;
                    cnt_restart = 1'b1;
                    partial_d   = 1'b0;
                    if (state_q == StRed) begin
                        locked_d = 1'b1;
                    end
                    if (state_q == StYellow) begin
                        cycle_d = cycle_q + 16'd1;
                    end
                end
            end
            default: ; // StError: lamps ignored, everything frozen
        endcase

        if (viol) begin
            state_d = StError;
            err_d   = 1'b1;
            code_d  = viol_code;
        end

        // Clear overrides anything sampled on the same edge, including a violation
        if (bus_io.clr_err) begin
            state_d     = StUnsync;
            err_d       = 1'b0;
            code_d      = ErrNone;
            locked_d    = 1'b0;
            partial_d   = 1'b0;
            cycle_d     = cycle_q;
            cnt_clr     = 1'b1;
            cnt_restart = 1'b0;
            cnt_inc     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StUnsync;
            err_q     <= 1'b0;
            code_q    <= ErrNone;
            locked_q  <= 1'b0;
            partial_q <= 1'b0;
            cycle_q   <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            code_q    <= code_d;
            locked_q  <= locked_d;
            partial_q <= partial_d;
            cycle_q   <= cycle_d;
        end
    end

    assign bus_io.phase       = phase_of(state_q);
    assign bus_io.locked      = locked_q;
    assign bus_io.err         = err_q;
    assign bus_io.err_code    = code_q;
    assign bus_io.dwell       = dwell;
    assign bus_io.cycle_count = cycle_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor with RED 3..5, GREEN 3..5, YEL 1..2.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] N = 3'b000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    traffic_light_monitor_if #(.CNT_W(8)) mon_if ();

    traffic_light_monitor #(
        .CNT_W     (8),
        .RED_MIN   (3),
        .RED_MAX   (5),
        .GREEN_MIN (3),
        .GREEN_MAX (5),
        .YEL_MIN   (1),
        .YEL_MAX   (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (mon_if)
    );

    typedef struct packed {
        logic [1:0]  phase;
        logic        locked;
        logic        err;
        logic [2:0]  code;
        logic [7:0]  dwell;
        logic [15:0] cycles;
    } obs_t;

    typedef struct {
        logic       clr;
        logic [2:0] lamps;
        obs_t       exp;
    } vec_t;

    vec_t vecs[$];
    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic obs_t ob(int ph, int lk, int e, int c, int dw, int cy);
        obs_t o;
        o.phase  = 2'(ph);
        o.locked = 1'(lk);
        o.err    = 1'(e);
        o.code   = 3'(c);
        o.dwell  = 8'(dw);
        o.cycles = 16'(cy);
        return o;
    endfunction

    function automatic vec_t mk(logic clr, logic [2:0] lamps,
                                int ph, int lk, int e, int c, int dw, int cy);
        vec_t v;
        v.clr   = clr;
        v.lamps = lamps;
        v.exp   = ob(ph, lk, e, c, dw, cy);
        return v;
    endfunction

    function automatic obs_t sample_dut();
        obs_t o;
        o.phase  = mon_if.phase;
        o.locked = mon_if.locked;
        o.err    = mon_if.err;
        o.code   = mon_if.err_code;
        o.dwell  = mon_if.dwell;
        o.cycles = mon_if.cycle_count;
        return o;
    endfunction

    task automatic check(input string name);
        obs_t act;
        obs_t req;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, nothing to compare", name);
            return;
        end
        req = exp_q.pop_front();
        act = sample_dut();
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got ph=%0d lk=%0d err=%0d code=%0d dw=%0d cyc=%0d, required ph=%0d lk=%0d err=%0d code=%0d dw=%0d cyc=%0d",
                     name, act.phase, act.locked, act.err, act.code, act.dwell, act.cycles,
                     req.phase, req.locked, req.err, req.code, req.dwell, req.cycles);
        end
    endtask

    task automatic step(input logic clr, input logic [2:0] lamps, input obs_t e, input string name);
        mon_if.clr_err = clr;
        {mon_if.Red, mon_if.Yellow, mon_if.Green} = lamps;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1. full legal sequence, partial first Red
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 4, 0));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 3, 0));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 4, 0));
        vecs.push_back(mk(0, Y, 3, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, Y, 3, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, R, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, R, 1, 1, 0, 0, 2, 1));
        vecs.push_back(mk(0, R, 1, 1, 0, 0, 3, 1));
        vecs.push_back(mk(0, R, 1, 1, 0, 0, 4, 1));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 1, 1));
        // 2. G x3 then R: illegal, later violation ignored, clr wins over R
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 2, 1));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 3, 1));
        vecs.push_back(mk(0, R, 0, 1, 1, 2, 3, 1));
        vecs.push_back(mk(0, 3'b111, 0, 1, 1, 2, 3, 1));
        vecs.push_back(mk(1, R, 0, 0, 0, 0, 0, 1));
        // 3. R+G together in GREEN
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 2, 1));
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 3'b101, 0, 1, 1, 1, 1, 1));
        vecs.push_back(mk(1, N, 0, 0, 0, 0, 0, 1));
        // 4. GREEN held 6 samples
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 2, 1));
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 2, 1));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 3, 1));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 4, 1));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 5, 1));
        vecs.push_back(mk(0, G, 0, 1, 1, 4, 5, 1));
        vecs.push_back(mk(1, N, 0, 0, 0, 0, 0, 1));
        // UNSYNC ignores anything but Red-only
        vecs.push_back(mk(0, G, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 3'b111, 0, 0, 0, 0, 0, 1));
        // 5. G x2 then Y: short green; clr with an illegal sample
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 2, 1));
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 2, 1));
        vecs.push_back(mk(0, Y, 0, 1, 1, 3, 2, 1));
        vecs.push_back(mk(1, 3'b110, 0, 0, 0, 0, 0, 1));
        // non-partial Red too short
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 2, 1));
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 2, 1));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 3, 1));
        vecs.push_back(mk(0, Y, 3, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, R, 1, 1, 0, 0, 1, 2));
        vecs.push_back(mk(0, R, 1, 1, 0, 0, 2, 2));
        vecs.push_back(mk(0, G, 0, 1, 1, 3, 2, 2));
        vecs.push_back(mk(1, N, 0, 0, 0, 0, 0, 2));
        // partial Red of 1 accepted; Yellow held 3 is too long
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 1, 2));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 2, 2));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 3, 2));
        vecs.push_back(mk(0, Y, 3, 1, 0, 0, 1, 2));
        vecs.push_back(mk(0, Y, 3, 1, 0, 0, 2, 2));
        vecs.push_back(mk(0, Y, 0, 1, 1, 4, 2, 2));
        // lead-in to 6: into YELLOW
        vecs.push_back(mk(1, N, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, R, 1, 0, 0, 0, 2, 2));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 1, 2));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 2, 2));
        vecs.push_back(mk(0, G, 2, 1, 0, 0, 3, 2));
        vecs.push_back(mk(0, Y, 3, 1, 0, 0, 1, 2));

        reset          = 1'b0;
        mon_if.clr_err = 1'b0;
        mon_if.Red     = 1'b0;
        mon_if.Yellow  = 1'b0;
        mon_if.Green   = 1'b0;
        #2;
        exp_q.push_back(ob(0, 0, 0, 0, 0, 0));
        check("reset_t0");
        @(posedge clk);
        #1;
        exp_q.push_back(ob(0, 0, 0, 0, 0, 0));
        check("reset_held");
        #2;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].clr, vecs[i].lamps, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // 6. asynchronous reset mid-YELLOW, away from any clock edge
        #3;
        reset = 1'b0;
        #1;
        exp_q.push_back(ob(0, 0, 0, 0, 0, 0));
        check("async_reset_now");
        @(posedge clk);
        #1;
        exp_q.push_back(ob(0, 0, 0, 0, 0, 0));
        check("async_reset_held");
        #2;
        reset = 1'b1;
        step(0, R, ob(1, 0, 0, 0, 1, 0), "resync_r1");
        step(0, G, ob(2, 1, 0, 0, 1, 0), "resync_g1");
        step(0, G, ob(2, 1, 0, 0, 2, 0), "resync_g2");
        step(0, G, ob(2, 1, 0, 0, 3, 0), "resync_g3");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
